// File: rtl/read_controller.sv
// Read-side buffer controller: drains one frame of FRAME_LEN words onto a valid/ready stream.
// Optional macro READ_PREFETCH_EN: a non-last accept with data available goes straight to READ.
module read_controller #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned FRAME_LEN = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              read_done
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ren_q, valid_q, done_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end
      S_CHECK: begin
        if (!empty) state_d = S_READ;
      end
      S_READ: begin
        raddr_d = raddr_q + ADDR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        data_d  = rdata;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = S_DONE;
          end else begin
`ifdef READ_PREFETCH_EN
            state_d = empty ? S_CHECK : S_READ;
`else
            state_d = S_CHECK;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs registered from the next state so they align with the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ren_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ren_q   <= (state_d == S_READ);
      valid_q <= (state_d == S_HOLD);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ren       = ren_q;
  assign raddr     = raddr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign read_done = done_q;

endmodule

// File: tb/tb_read_controller.sv
// Bench for read_controller: event-level buffer/stream model compared every cycle, plus pinned frames.
module tb_read_controller;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned FRAME_LEN = 9;
  localparam int unsigned DEPTH     = 16;

  logic              clk = 1'b0;
  logic              rst, start, empty, out_ready;
  logic [DATA_W-1:0] rdata;
  logic              ren, out_valid, read_done;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] got_q [$];
  int first_ren, first_valid, done_cnt;
  int base;

  // Reference: what the outputs must be this cycle
  logic              m_ren, m_valid, m_done, m_poll, m_busy, m_pipe;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_pdata;
  int                m_cnt;
  logic              n_ren, n_valid, n_done, n_poll, n_busy, n_pipe, acc;
  logic [ADDR_W-1:0] n_addr;
  logic [DATA_W-1:0] n_data, n_pdata;
  int                n_cnt;

  read_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .empty     (empty),
    .rdata     (rdata),
    .ren       (ren),
    .raddr     (raddr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .read_done (read_done)
  );

  always #5 clk = ~clk;

  // Buffer: word appears the cycle after ren
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A read is owed after start or a non-last accept; it issues the cycle after empty is seen low,
  // its word is presented two cycles later and held until accepted.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ren = 1'b0; m_addr = '0; m_valid = 1'b0; m_data = '0; m_done = 1'b0;
      m_poll = 1'b0; m_busy = 1'b0; m_cnt = 0; m_pipe = 1'b0; m_pdata = '0;
    end else begin
      acc     = m_valid && out_ready;
      n_ren   = 1'b0;
      n_poll  = m_poll;
      n_busy  = m_busy;
      n_cnt   = m_cnt;
      n_done  = 1'b0;
      n_pipe  = m_ren;
      n_pdata = mem[m_addr];
      n_valid = m_valid && !out_ready;
      n_data  = m_data;
      n_addr  = m_ren ? m_addr + 4'd1 : m_addr;
      if (!m_busy && start) begin
        n_busy = 1'b1; n_poll = 1'b1; n_cnt = 0;
      end
      if (m_poll && !empty) begin
        n_ren = 1'b1; n_poll = 1'b0;
      end
      if (m_pipe) begin
        n_valid = 1'b1; n_data = m_pdata;
      end
      if (acc) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == FRAME_LEN) n_done = 1'b1;
`ifdef READ_PREFETCH_EN
        else if (!empty) n_ren = 1'b1;
`endif
        else n_poll = 1'b1;
      end
      if (m_done) n_busy = 1'b0;
      m_ren = n_ren; m_poll = n_poll; m_busy = n_busy; m_cnt = n_cnt; m_done = n_done;
      m_pipe = n_pipe; m_pdata = n_pdata; m_valid = n_valid; m_data = n_data; m_addr = n_addr;
    end
  end

  // Compare and monitor, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ren", 32'(ren), 32'(m_ren));
      check("raddr", 32'(raddr), 32'(m_addr));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("read_done", 32'(read_done), 32'(m_done));
      if (ren && first_ren < 0) first_ren = cyc;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (read_done) done_cnt++;
    end
  end

  task automatic run_frame(input bit rnd, input int hold_empty, input int stall, input bit pin_lat);
    int n, s, stall_left;
    bit stalled, done_seen;
    got_q.delete();
    first_ren = -1; first_valid = -1; done_cnt = 0;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; stall_left = 0; stalled = 1'b0; done_seen = 1'b0;
    while (!done_seen && n < 400) begin
      if (read_done) done_seen = 1'b1;
      if (rnd) begin
        empty     = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        start     = (out_valid || read_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (hold_empty > 0) empty = (n < hold_empty);
      if (stall > 0) begin
        if (!stalled && out_valid) begin
          stalled = 1'b1; stall_left = stall;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else out_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("frame_done_seen", 32'(done_seen), 32'd1);
    check("frame_word_count", 32'(got_q.size()), 32'(FRAME_LEN));
    for (int k = 0; k < got_q.size(); k++)
      check("frame_word", 32'(got_q[k]), 32'(mem[4'(base + k)]));
    check("frame_done_pulses", 32'(done_cnt), 32'd1);
    if (pin_lat) begin
      check("ren_latency", 32'(first_ren - s), 32'(2 + hold_empty));
      check("valid_latency", 32'(first_valid - s), 32'(4 + hold_empty));
    end
    base = (base + FRAME_LEN) % DEPTH;
    check("raddr_after_frame", 32'(raddr), 32'(base));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; empty = 1'b0; out_ready = 1'b1; rdata = '0; base = 0;
    first_ren = -1; first_valid = -1; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h100 + 16'(i);
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_ren", 32'(ren), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_read_done", 32'(read_done), 32'd0);
    check("reset_raddr", 32'(raddr), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Frame of 0x100.. words with a free-flowing consumer
    run_frame(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < got_q.size(); k++) check("directed_word", 32'(got_q[k]), 32'h100 + 32'(k));
    check("directed_raddr", 32'(raddr), 32'd9);

    run_frame(1'b0, 5, 0, 1'b1);
    empty = 1'b0;
    run_frame(1'b0, 0, 6, 1'b0);
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(1'b1, 0, 0, 1'b0);
    empty = 1'b0; out_ready = 1'b1;
    check("pre_wrap_raddr", 32'(raddr), 32'd15);

    // Frame straddling the address wrap
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h200 + 16'(i);
    run_frame(1'b0, 0, 0, 1'b0);
    check("wrap_word0", 32'(got_q[0]), 32'h20F);
    check("wrap_word1", 32'(got_q[1]), 32'h200);
    check("wrap_raddr", 32'(raddr), 32'd8);

    // Reset while a word is held
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_hold", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_raddr", 32'(raddr), 32'd0);
    check("rst_hold_ren", 32'(ren), 32'd0);
    base = 0;
    out_ready = 1'b1;

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      run_frame(1'b1, 0, 0, 1'b0);
      empty = 1'b0; out_ready = 1'b1;
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
